// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tpu_pkg
// Brief   : Shared TPU widths, slot/timer types and register-map addresses.
// Revision: 1.0
// ============================================================================
package tpu_pkg;

  localparam int SLOT_W  = 8;
  localparam int TIMER_W = 16;

  typedef logic [SLOT_W-1:0]  slot_t;
  typedef logic [TIMER_W-1:0] tint_t;

  // Register-file map, shared with the TPU register file
  localparam logic [7:0] ADDR_TXSLOT    = 8'h20;
  localparam logic [7:0] ADDR_RXSLOT    = 8'h21;
  localparam logic [7:0] ADDR_TINT_LO   = 8'h22;
  localparam logic [7:0] ADDR_TINT_HI   = 8'h23;
  localparam logic [7:0] ADDR_TPUCTRL   = 8'h24;

endpackage
`default_nettype wire

// File: rtl/tpu_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tpu_prescaler
// Brief   : Divides SYS_CLK into slot periods; tick marks the last cycle.
// Revision: 1.0
// ============================================================================
module tpu_prescaler #(
  parameter int CLKS_PER_SLOT = 100
) (
  input  logic SYS_CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int c_cnt_w = (CLKS_PER_SLOT > 1) ? $clog2(CLKS_PER_SLOT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_SLOT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge SYS_CLK) begin
    if (RST || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/tpu_slot_timer.sv
`default_nettype none
// ============================================================================
// Module  : tpu_slot_timer
// Brief   : TPU time base: slot counter, TX/RX slot events, timer interrupt.
// Revision: 1.0
// ============================================================================
module tpu_slot_timer
  import tpu_pkg::*;
#(
  parameter int CLKS_PER_SLOT = 100,
  parameter int NUM_SLOTS     = 256
) (
  input  logic  SYS_CLK,
  input  logic  RST,
  input  logic  RSTTPU,
  input  logic  TXSLOT_EN,
  input  logic  RXSLOT_EN,
  input  slot_t TX_SLOT,
  input  slot_t RX_SLOT,
  input  tint_t TIMER_INT_VALUE,
  input  logic  TIMERINTMSK,
  input  logic  INT_CLR,
  output slot_t TIME,
  output logic  SLOT_TICK,
  output logic  TX_START,
  output logic  RX_START,
  output logic  TX_ACTIVE,
  output logic  RX_ACTIVE,
  output logic  TPUINT_RF
);

  localparam slot_t c_last_slot = slot_t'(NUM_SLOTS - 1);

  logic               w_tick;
  slot_t              w_next_time;
  logic [TIMER_W:0]   w_cnt_inc;
  logic               w_int_run;
  logic               w_int_match;

  slot_t              r_time;
  tint_t              r_int_cnt;
  logic               r_slot_tick;
  logic               r_tx_start;
  logic               r_rx_start;
  logic               r_int_flag;

  tpu_prescaler #(
    .CLKS_PER_SLOT (CLKS_PER_SLOT)
  ) u_prescaler (
    .SYS_CLK (SYS_CLK),
    .RST     (RST),
    .clr     (RSTTPU),
    .tick    (w_tick)
  );

  assign w_next_time = (r_time == c_last_slot) ? '0 : r_time + slot_t'(1);

  // Extra bit keeps the >= compare exact even at the top of the 16-bit range
  assign w_cnt_inc   = {1'b0, r_int_cnt} + (TIMER_W + 1)'(1);
  assign w_int_run   = w_tick && (TIMER_INT_VALUE != '0);
  assign w_int_match = w_int_run && (w_cnt_inc >= {1'b0, TIMER_INT_VALUE});

  always_ff @(posedge SYS_CLK) begin
    if (RST || RSTTPU) begin
      r_time      <= '0;
      r_int_cnt   <= '0;
      r_slot_tick <= 1'b0;
      r_tx_start  <= 1'b0;
      r_rx_start  <= 1'b0;
      r_int_flag  <= 1'b0;
    end else begin
      r_slot_tick <= w_tick;
      r_tx_start  <= w_tick && TXSLOT_EN && (w_next_time == TX_SLOT);
      r_rx_start  <= w_tick && RXSLOT_EN && (w_next_time == RX_SLOT);

      if (w_tick) begin
        r_time <= w_next_time;
      end

      if (w_int_run) begin
        r_int_cnt <= w_int_match ? '0 : w_cnt_inc[TIMER_W-1:0];
      end

      // A set in the same cycle as a clear wins so no event is lost
      if (w_int_match && TIMERINTMSK) begin
        r_int_flag <= 1'b1;
      end else if (INT_CLR) begin
        r_int_flag <= 1'b0;
      end
    end
  end

  assign TIME      = r_time;
  assign SLOT_TICK = r_slot_tick;
  assign TX_START  = r_tx_start;
  assign RX_START  = r_rx_start;
  assign TPUINT_RF = r_int_flag;
  assign TX_ACTIVE = TXSLOT_EN && (r_time == TX_SLOT);
  assign RX_ACTIVE = RXSLOT_EN && (r_time == RX_SLOT);

endmodule
`default_nettype wire

// File: tb/tb_tpu_slot_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_tpu_slot_timer
// Brief   : Directed self-checking bench for tpu_slot_timer (4 clk/slot, 8 slots).
// Revision: 1.0
// ============================================================================
module tb_tpu_slot_timer;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RSTTPU = 1'b0;
  logic        TXSLOT_EN = 1'b0;
  logic        RXSLOT_EN = 1'b0;
  logic [7:0]  TX_SLOT = '0;
  logic [7:0]  RX_SLOT = '0;
  logic [15:0] TIMER_INT_VALUE = '0;
  logic        TIMERINTMSK = 1'b0;
  logic        INT_CLR = 1'b0;
  logic [7:0]  TIME;
  logic        SLOT_TICK;
  logic        TX_START;
  logic        RX_START;
  logic        TX_ACTIVE;
  logic        RX_ACTIVE;
  logic        TPUINT_RF;

  int n_vec  = 0;
  int n_miss = 0;

  tpu_slot_timer #(
    .CLKS_PER_SLOT (4),
    .NUM_SLOTS     (8)
  ) dut (
    .SYS_CLK         (SYS_CLK),
    .RST             (RST),
    .RSTTPU          (RSTTPU),
    .TXSLOT_EN       (TXSLOT_EN),
    .RXSLOT_EN       (RXSLOT_EN),
    .TX_SLOT         (TX_SLOT),
    .RX_SLOT         (RX_SLOT),
    .TIMER_INT_VALUE (TIMER_INT_VALUE),
    .TIMERINTMSK     (TIMERINTMSK),
    .INT_CLR         (INT_CLR),
    .TIME            (TIME),
    .SLOT_TICK       (SLOT_TICK),
    .TX_START        (TX_START),
    .RX_START        (RX_START),
    .TX_ACTIVE       (TX_ACTIVE),
    .RX_ACTIVE       (RX_ACTIVE),
    .TPUINT_RF       (TPUINT_RF)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge SYS_CLK);
    #1;
  endtask

  initial begin
    step(3);
    check_vec("rst_time", TIME, 0);
    check_vec("rst_tick", SLOT_TICK, 0);
    check_vec("rst_int", TPUINT_RF, 0);
    check_vec("rst_txs", TX_START, 0);
    RST = 1'b0;

    // Slot counting and wrap: tick k lands on cycle 4k
    for (int k = 1; k <= 8; k++) begin
      step(3);
      check_vec("tick_low", SLOT_TICK, 0);
      step(1);
      check_vec("tick_high", SLOT_TICK, 1);
      check_vec("time_seq", TIME, k % 8);
    end

    // Shared TX/RX slot 3 (cycle 32 -> TIME=3 at cycle 44)
    TX_SLOT = 8'd3; RX_SLOT = 8'd3; TXSLOT_EN = 1'b1; RXSLOT_EN = 1'b1;
    step(11);
    check_vec("pre_time", TIME, 2);
    check_vec("pre_txact", TX_ACTIVE, 0);
    check_vec("pre_txs", TX_START, 0);
    step(1);
    check_vec("s3_time", TIME, 3);
    check_vec("s3_txs", TX_START, 1);
    check_vec("s3_rxs", RX_START, 1);
    check_vec("s3_txact", TX_ACTIVE, 1);
    check_vec("s3_rxact", RX_ACTIVE, 1);
    step(1);
    check_vec("s3_txs_end", TX_START, 0);
    check_vec("s3_txact2", TX_ACTIVE, 1);
    TXSLOT_EN = 1'b0;
    #1;
    check_vec("txact_drop", TX_ACTIVE, 0);
    check_vec("rxact_keep", RX_ACTIVE, 1);
    step(2);
    check_vec("rxact_last", RX_ACTIVE, 1);
    step(1);
    check_vec("rxact_off", RX_ACTIVE, 0);
    check_vec("s4_time", TIME, 4);

    // Slot 0 after wrap fires; slot 8 is out of range and never matches
    TX_SLOT = 8'd0; TXSLOT_EN = 1'b1; RX_SLOT = 8'd8; RXSLOT_EN = 1'b1;
    step(16);
    check_vec("wrap_time", TIME, 0);
    check_vec("wrap_txs", TX_START, 1);
    check_vec("oor_rxs", RX_START, 0);
    check_vec("oor_rxact", RX_ACTIVE, 0);
    TXSLOT_EN = 1'b0; RXSLOT_EN = 1'b0;

    // Interrupt period 3, clear, and set-beats-clear
    TIMER_INT_VALUE = 16'd3; TIMERINTMSK = 1'b1;
    step(8);
    check_vec("int_t2", TPUINT_RF, 0);
    step(4);
    check_vec("int_t3", TPUINT_RF, 1);
    INT_CLR = 1'b1;
    step(1);
    INT_CLR = 1'b0;
    check_vec("int_clr", TPUINT_RF, 0);
    step(10);
    check_vec("int_pre6", TPUINT_RF, 0);
    step(1);
    check_vec("int_t6", TPUINT_RF, 1);
    INT_CLR = 1'b1;
    step(1);
    INT_CLR = 1'b0;
    check_vec("int_clr2", TPUINT_RF, 0);
    step(10);
    check_vec("int_pre9", TPUINT_RF, 0);
    INT_CLR = 1'b1;
    step(1);
    INT_CLR = 1'b0;
    check_vec("set_wins", TPUINT_RF, 1);
    check_vec("t100_time", TIME, 1);

    // Lowering the period mid-count matches on the next tick
    TIMER_INT_VALUE = 16'd10; INT_CLR = 1'b1;
    step(1);
    INT_CLR = 1'b0;
    step(23);
    check_vec("p10_t6", TPUINT_RF, 0);
    TIMER_INT_VALUE = 16'd4;
    step(3);
    check_vec("p4_pre", TPUINT_RF, 0);
    step(1);
    check_vec("p4_t7", TPUINT_RF, 1);

    // Period 0 freezes the counter: restart at 2 needs two full ticks
    TIMER_INT_VALUE = 16'd0; INT_CLR = 1'b1;
    step(1);
    INT_CLR = 1'b0;
    step(12);
    check_vec("halt_int", TPUINT_RF, 0);
    TIMER_INT_VALUE = 16'd2;
    step(6);
    check_vec("frozen", TPUINT_RF, 0);
    step(1);
    check_vec("resume", TPUINT_RF, 1);
    check_vec("t148_time", TIME, 5);

    // RSTTPU mid-slot, then coincident with a tick
    TIMER_INT_VALUE = 16'd0;
    step(2);
    RSTTPU = 1'b1;
    step(1);
    RSTTPU = 1'b0;
    check_vec("srst_time", TIME, 0);
    check_vec("srst_int", TPUINT_RF, 0);
    step(3);
    check_vec("srst_notick", SLOT_TICK, 0);
    step(1);
    check_vec("srst_tick", SLOT_TICK, 1);
    check_vec("srst_t1", TIME, 1);
    step(3);
    TX_SLOT = 8'd2; TXSLOT_EN = 1'b1; RSTTPU = 1'b1;
    step(1);
    RSTTPU = 1'b0;
    check_vec("srst_kill_tick", SLOT_TICK, 0);
    check_vec("srst_kill_txs", TX_START, 0);
    check_vec("srst_kill_time", TIME, 0);
    TXSLOT_EN = 1'b0;

    // Masked matches still reload the counter
    TIMERINTMSK = 1'b0; TIMER_INT_VALUE = 16'd2;
    step(24);
    check_vec("msk_hold", TPUINT_RF, 0);
    TIMERINTMSK = 1'b1;
    step(7);
    check_vec("msk_pre8", TPUINT_RF, 0);
    step(1);
    check_vec("msk_t8", TPUINT_RF, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
